// File: rtl/instr_encoder_pkg.sv
// encoder_pkg: shared types and constants for the RV32I instruction encoder.
// Holds the format/state enums, the opcodes the loader is expected to see,
// the immediate range limits, and the combinational pack-and-range-check
// function used by instr_encoder.
package encoder_pkg;

  typedef enum logic [1:0] {
    FMT_R = 2'b00,
    FMT_I = 2'b01,
    FMT_S = 2'b10,
    FMT_B = 2'b11
  } fmt_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_RUN   = 2'b01,
    ST_DRAIN = 2'b10,
    ST_DONE  = 2'b11
  } state_e;

  localparam logic [6:0] OP_R    = 7'b0110011;
  localparam logic [6:0] OP_I    = 7'b0010011;
  localparam logic [6:0] OP_LOAD = 7'b0000011;
  localparam logic [6:0] OP_S    = 7'b0100011;
  localparam logic [6:0] OP_B    = 7'b1100011;

  // Legal immediate windows (B is a byte offset, so its window is doubled).
  localparam int IMM12_MIN = -2048;
  localparam int IMM12_MAX = 2047;
  localparam int IMMB_MIN  = -4096;
  localparam int IMMB_MAX  = 4094;

  typedef struct packed {
    logic        ok;
    logic [31:0] word;
  } enc_t;

  // Pack one field bundle into a 32-bit word and flag whether its immediate
  // is representable in the chosen format.
  function automatic enc_t encode(input fmt_e fmt, input logic [6:0] op,
                                  input logic [2:0] f3, input logic [6:0] f7,
                                  input logic [4:0] rd, input logic [4:0] rs1,
                                  input logic [4:0] rs2, input logic [12:0] imm);
    enc_t r;
    int   simm;
    simm   = int'($signed(imm));
    r.ok   = 1'b1;
    r.word = 32'h0000_0000;
    case (fmt)
      FMT_R: begin
        r.word = {f7, rs2, rs1, f3, rd, op};
        r.ok   = 1'b1;
      end
      FMT_I: begin
        r.word = {imm[11:0], rs1, f3, rd, op};
        r.ok   = (simm >= IMM12_MIN) && (simm <= IMM12_MAX);
      end
      FMT_S: begin
        r.word = {imm[11:5], rs2, rs1, f3, imm[4:0], op};
        r.ok   = (simm >= IMM12_MIN) && (simm <= IMM12_MAX);
      end
      FMT_B: begin
        r.word = {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], op};
        r.ok   = (simm >= IMMB_MIN) && (simm <= IMMB_MAX) && (imm[0] == 1'b0);
      end
      default: begin
        r.word = 32'h0000_0000;
        r.ok   = 1'b0;
      end
    endcase
    return r;
  endfunction

endpackage

// File: rtl/instr_encoder_fifo.sv
// sync_fifo: single-clock FIFO with registered storage and flags.
// Ports: clk, rst (sync active-low), push/din write side, pop/dout read side
// (dout is the current head), full/empty flags, count = occupancy.
// Push and pop in the same cycle leave occupancy unchanged. Storage is
// cleared on reset so the head reads zero while idle after reset.
module sync_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4,
  localparam int AW   = $clog2(DEPTH),
  localparam int CW   = AW + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty,
  output logic [CW-1:0]    count
);

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [AW-1:0]    wr_ptr_r, rd_ptr_r;
  logic [CW-1:0]    count_r, count_next_s;
  logic             full_r, empty_r;
  logic             do_push_s, do_pop_s;

  assign do_push_s = push && !full_r;
  assign do_pop_s  = pop && !empty_r;
  assign dout      = mem_r[rd_ptr_r];
  assign full      = full_r;
  assign empty     = empty_r;
  assign count     = count_r;

  // Next occupancy from the qualified push/pop pair.
  always_comb begin
    count_next_s = count_r;
    if (do_push_s && !do_pop_s) begin
      count_next_s = count_r + CW'(1);
    end else if (!do_push_s && do_pop_s) begin
      count_next_s = count_r - CW'(1);
    end else begin
      count_next_s = count_r;
    end
  end

  // Storage, pointers and registered flags.
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= '0;
      end
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      count_r  <= '0;
      full_r   <= 1'b0;
      empty_r  <= 1'b1;
    end else begin
      if (do_push_s) begin
        mem_r[wr_ptr_r] <= din;
        wr_ptr_r        <= wr_ptr_r + AW'(1);
      end
      if (do_pop_s) begin
        rd_ptr_r <= rd_ptr_r + AW'(1);
      end
      count_r <= count_next_s;
      full_r  <= (count_next_s == CW'(DEPTH));
      empty_r <= (count_next_s == CW'(0));
    end
  end

endmodule

// File: rtl/instr_encoder.sv
// instr_encoder: accepts RV32I field bundles (R/I/S/B), packs and range
// checks them, queues the words and streams them to instruction memory
// at incrementing word addresses.
// Ports: start/base_addr open a session; in_* bundle handshake (in_ready out);
// mem_valid/mem_ready/mem_addr/mem_wdata memory write stream;
// busy, done (1-cycle), err (sticky per session), words (written count).
module instr_encoder
  import encoder_pkg::*;
#(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [1:0]        in_fmt,
  input  logic [6:0]        in_op,
  input  logic [2:0]        in_funct3,
  input  logic [6:0]        in_funct7,
  input  logic [4:0]        in_rd,
  input  logic [4:0]        in_rs1,
  input  logic [4:0]        in_rs2,
  input  logic [12:0]       in_imm,
  input  logic              in_last,
  output logic              mem_valid,
  input  logic              mem_ready,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [15:0]       words
);

  localparam int CW = $clog2(DEPTH) + 1;

  state_e            state_r;
  logic [ADDR_W-1:0] addr_r;
  logic [15:0]       words_r;
  logic              err_r, busy_r, done_r;

  enc_t              enc_s;
  logic              accept_s, push_s, pop_s;
  logic              fifo_full_s, fifo_empty_s;
  logic [CW-1:0]     fifo_count_s;

  assign enc_s     = encode(fmt_e'(in_fmt), in_op, in_funct3, in_funct7,
                            in_rd, in_rs1, in_rs2, in_imm);
  assign in_ready  = (state_r == ST_RUN) && !fifo_full_s;
  assign accept_s  = in_valid && in_ready;
  // Rejected bundles still complete the handshake but never enter the FIFO.
  assign push_s    = accept_s && enc_s.ok;
  assign mem_valid = !fifo_empty_s;
  assign pop_s     = mem_valid && mem_ready;

  assign mem_addr  = addr_r;
  assign busy      = busy_r;
  assign done      = done_r;
  assign err       = err_r;
  assign words     = words_r;

  sync_fifo #(
    .WIDTH(32),
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk  (clk),
    .rst  (rst),
    .push (push_s),
    .din  (enc_s.word),
    .pop  (pop_s),
    .dout (mem_wdata),
    .full (fifo_full_s),
    .empty(fifo_empty_s),
    .count(fifo_count_s)
  );

  // Session FSM plus address/word/error bookkeeping.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_r <= ST_IDLE;
      addr_r  <= '0;
      words_r <= 16'h0000;
      err_r   <= 1'b0;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
    end else begin
      if (pop_s) begin
        addr_r <= addr_r + ADDR_W'(4);
        if (words_r != 16'hFFFF) begin
          words_r <= words_r + 16'd1;
        end
      end
      if (accept_s && !enc_s.ok) begin
        err_r <= 1'b1;
      end
      case (state_r)
        ST_IDLE: begin
          // Placed after the bookkeeping so session setup takes priority.
          if (start) begin
            state_r <= ST_RUN;
            busy_r  <= 1'b1;
            addr_r  <= {base_addr[ADDR_W-1:2], 2'b00};
            err_r   <= 1'b0;
            words_r <= 16'h0000;
          end
        end
        ST_RUN: begin
          if (accept_s && in_last) begin
            state_r <= ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          // Leave on the final pop itself so done follows it by one cycle.
          if (fifo_empty_s || (fifo_count_s == CW'(1) && pop_s)) begin
            state_r <= ST_DONE;
            done_r  <= 1'b1;
          end
        end
        ST_DONE: begin
          state_r <= ST_IDLE;
          done_r  <= 1'b0;
          busy_r  <= 1'b0;
        end
        default: begin
          state_r <= ST_IDLE;
          done_r  <= 1'b0;
          busy_r  <= 1'b0;
        end
      endcase
    end
  end

endmodule
